// File: rtl/mult_table_checker_pkg.sv
// mult_pkg: shared widths, sweep size and state encoding for the times-table checker
package mult_pkg;
    localparam int OP_W   = 3;
    localparam int PAIRS  = 64;
    localparam int PROD_W = 6;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;
endpackage

// File: rtl/mult_table_checker_lat_counter.sv
// lat_counter: loadable down-counter with zero flag, times the memory read latency
// ports: clk, rst_n (async active-low), load/load_val (preset), dec (count down), zero (count is 0)
module lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/mult_table_checker.sv
// mult_table_checker: sweeps all 8x8 operand pairs through the times-table memory and checks each result
// ports: clk, rst_n (async active-low), start (begin sweep from IDLE/DONE);
//        a, b, read -> memory request; result <- memory data;
//        busy, done, pass, err_count, first_err_a, first_err_b -> sweep status and report
module mult_table_checker
    import mult_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int RESULT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [OP_W-1:0]     a,
    output logic [OP_W-1:0]     b,
    output logic                read,
    input  logic [RESULT_W-1:0] result,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [6:0]          err_count,
    output logic [OP_W-1:0]     first_err_a,
    output logic [OP_W-1:0]     first_err_b
);
    state_t state, nxt;
    logic [2*OP_W-1:0] ab;
    logic [PROD_W-1:0] prod;
    logic [RESULT_W-1:0] res_q;
    logic lat_zero, err_seen, launch, mismatch;
    assign ab       = {a, b};
    assign prod     = PROD_W'(a) * PROD_W'(b);
    assign launch   = (state == S_IDLE || state == S_DONE) && start;
    // only the low RESULT_W bits of the product are stored by the memory
    assign mismatch = res_q != RESULT_W'(prod);
    lat_counter #(.W(3)) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == S_ISSUE),
        .dec      (state == S_WAIT),
        .load_val (3'(READ_LAT - 1)),
        .zero     (lat_zero)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: nxt = start ? S_ISSUE : state;
            S_ISSUE:        nxt = S_WAIT;
            S_WAIT:         nxt = lat_zero ? S_CHECK : S_WAIT;
            S_CHECK:        nxt = ab == 6'(PAIRS - 1) ? S_DONE : S_ISSUE;
            default:        nxt = S_IDLE;
        endcase
    end
    always_comb begin
        read = state == S_ISSUE;
        busy = state == S_ISSUE || state == S_WAIT || state == S_CHECK;
        done = state == S_DONE;
        pass = done && err_count == '0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a           <= '0;
            b           <= '0;
            res_q       <= '0;
            err_count   <= '0;
            err_seen    <= 1'b0;
            first_err_a <= '0;
            first_err_b <= '0;
        end else begin
            if (launch) begin
                a           <= '0;
                b           <= '0;
                err_count   <= '0;
                err_seen    <= 1'b0;
                first_err_a <= '0;
                first_err_b <= '0;
            end
            // last WAIT cycle ends on the edge where the memory output is valid
            if (state == S_WAIT && lat_zero)
                res_q <= result;
            if (state == S_CHECK) begin
                if (mismatch) begin
                    err_count <= err_count + 7'd1;
                    if (!err_seen) begin
                        err_seen    <= 1'b1;
                        first_err_a <= a;
                        first_err_b <= b;
                    end
                end
                if (ab != 6'(PAIRS - 1))
                    {a, b} <= ab + 6'd1;
            end
        end
endmodule

// File: tb/tb_mult_table_checker.sv
// tb_mult_table_checker: randomized self-check of the sweep checker against behavioural memories
module tb_mult_table_checker;
    logic clk = 1'b0, rst_n = 1'b0, start_drv = 1'b0;
    int sel = 1, mode = 0;
    logic [63:0] mask = '0;
    int errors = 0, checks = 0;
    int done_cyc, n_reads, read_bad;
    int e_err, e_fa, e_fb;

    logic start1, read1, busy1, done1, pass1;
    logic [2:0] a1, b1, fa1, fb1;
    logic [5:0] result1;
    logic [6:0] err1;
    logic start3, read3, busy3, done3, pass3;
    logic [2:0] a3, b3, fa3, fb3;
    logic [3:0] result3;
    logic [6:0] err3;

    logic rd_s, done_s, busy_s, pass_s;
    logic [6:0] err_s;
    logic [2:0] fa_s, fb_s;

    always #5 clk = ~clk;

    assign start1 = start_drv && sel == 1;
    assign start3 = start_drv && sel == 3;

    mult_table_checker #(.READ_LAT(1), .RESULT_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .read(read1),
        .result(result1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_a(fa1), .first_err_b(fb1)
    );
    mult_table_checker #(.READ_LAT(3), .RESULT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .read(read3),
        .result(result3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_a(fa3), .first_err_b(fb3)
    );

    // what the (possibly faulty) memory stores for a pair
    function automatic logic [5:0] mem_val(input int x, input int y, input int md, input logic [63:0] mk);
        int p = x * y;
        case (md)
            1: p = (x == 5 && y == 3) ? 0 : p;
            2: p = (x == 7) ? 6 * y : p;
            3: p = mk[x*8+y] ? p ^ 1 : p;
            default: ;
        endcase
        return 6'(p);
    endfunction

    // memories: data valid only in the single cycle READ_LAT edges after read; otherwise a wrong value
    logic v1;
    logic [5:0] d1;
    always @(posedge clk) begin
        v1 <= read1;
        d1 <= mem_val(int'(a1), int'(b1), mode, mask);
    end
    assign result1 = v1 ? d1 : ~6'(int'(a1) * int'(b1));

    logic [2:0] v3;
    logic [2:0][5:0] d3;
    always @(posedge clk) begin
        v3 <= {v3[1:0], read3};
        d3 <= {d3[1:0], mem_val(int'(a3), int'(b3), mode, mask)};
    end
    assign result3 = v3[2] ? d3[2][3:0] : ~4'(int'(a3) * int'(b3));

    always_comb begin
        rd_s   = sel == 1 ? read1 : read3;
        done_s = sel == 1 ? done1 : done3;
        busy_s = sel == 1 ? busy1 : busy3;
        pass_s = sel == 1 ? pass1 : pass3;
        err_s  = sel == 1 ? err1  : err3;
        fa_s   = sel == 1 ? fa1   : fa3;
        fb_s   = sel == 1 ? fb1   : fb3;
    end

    // reference: walk the table in sweep order and count truncated mismatches
    task automatic ref_model(input int md, input logic [63:0] mk, input int w);
        int m = (1 << w) - 1;
        e_err = 0; e_fa = 0; e_fb = 0;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                if ((int'(mem_val(x, y, md, mk)) & m) != ((x * y) & m)) begin
                    e_err++;
                    if (e_err == 1) begin e_fa = x; e_fb = y; end
                end
    endtask

    task automatic run_sweep(input int lat, input bit hold);
        int cyc = 0;
        int p = lat + 2;
        n_reads = 0; read_bad = 0; done_cyc = -1;
        @(negedge clk); start_drv = 1'b1;
        @(negedge clk); if (!hold) start_drv = 1'b0;
        while (cyc < 2000) begin
            if (rd_s) begin
                if (cyc != n_reads * p) read_bad++;
                n_reads++;
            end
            if (done_s) begin done_cyc = cyc; break; end
            @(negedge clk); cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_drv = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a1, b1, read1, busy1, done1, pass1, err1, fa1, fb1} !== 23'd0) begin
            errors++; $display("FAIL reset_l1: got %h expected 0", {a1, b1, read1, busy1, done1, pass1, err1, fa1, fb1});
        end
        checks++;
        if ({a3, b3, read3, busy3, done3, pass3, err3, fa3, fb3} !== 23'd0) begin
            errors++; $display("FAIL reset_l3: got %h expected 0", {a3, b3, read3, busy3, done3, pass3, err3, fa3, fb3});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_fixed_fault(input string name, input int md, input int lat);
        sel = lat; mode = md;
        ref_model(md, mask, lat == 1 ? 6 : 4);
        run_sweep(lat, 1'b0);
        checks++;
        if (done_cyc != 64 * (lat + 2) || n_reads != 64 || read_bad != 0) begin
            errors++; $display("FAIL %s_timing: done_cyc=%0d reads=%0d late_reads=%0d expected %0d/64/0", name, done_cyc, n_reads, read_bad, 64 * (lat + 2));
        end
        checks++;
        if ({err_s, pass_s, fa_s, fb_s} !== {7'(e_err), e_err == 0, 3'(e_fa), 3'(e_fb)}) begin
            errors++; $display("FAIL %s_report: err=%0d pass=%0b first=(%0d,%0d) expected err=%0d pass=%0b first=(%0d,%0d)", name, err_s, pass_s, fa_s, fb_s, e_err, e_err == 0, e_fa, e_fb);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) begin
            mask = {$urandom, $urandom} & {$urandom, $urandom};
            test_fixed_fault("random", 3, (i % 2) ? 3 : 1);
        end
    endtask

    task automatic test_reset_mid;
        sel = 1; mode = 3; mask = '1;
        @(negedge clk); start_drv = 1'b1;
        @(negedge clk); start_drv = 1'b0;
        repeat (61) @(negedge clk);
        checks++;
        if (err1 !== 7'd20) begin
            errors++; $display("FAIL mid_errs: got %0d expected 20", err1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, read1, err1, done1, a1, b1} !== 16'd0) begin
            errors++; $display("FAIL mid_async_reset: got %h expected 0", {busy1, read1, err1, done1, a1, b1});
        end
        @(negedge clk); rst_n = 1'b1;
        test_fixed_fault("after_reset", 0, 1);
    endtask

    task automatic test_back_to_back;
        int c = 0;
        sel = 1; mode = 2;
        run_sweep(1, 1'b1);
        checks++;
        if (done_cyc != 192 || err1 !== 7'd7 || fa1 !== 3'd7 || fb1 !== 3'd1 || pass1 !== 1'b0) begin
            errors++; $display("FAIL b2b_first: done_cyc=%0d err=%0d first=(%0d,%0d) pass=%0b expected 192/7/(7,1)/0", done_cyc, err1, fa1, fb1, pass1);
        end
        mode = 0;
        @(negedge clk);
        checks++;
        if ({busy1, done1, read1, err1} !== {1'b1, 1'b0, 1'b1, 7'd0}) begin
            errors++; $display("FAIL b2b_restart: busy=%0b done=%0b read=%0b err=%0d expected 1/0/1/0", busy1, done1, read1, err1);
        end
        start_drv = 1'b0;
        while (!done1 && c < 1000) begin @(negedge clk); c++; end
        checks++;
        if (c != 192 || err1 !== 7'd0 || pass1 !== 1'b1) begin
            errors++; $display("FAIL b2b_second: cycles=%0d err=%0d pass=%0b expected 192/0/1", c, err1, pass1);
        end
    endtask

    initial begin
        test_reset;
        test_fixed_fault("clean", 0, 1);
        test_fixed_fault("single", 1, 1);
        test_fixed_fault("row7", 2, 1);
        test_fixed_fault("lat3_clean", 0, 3);
        test_fixed_fault("lat3_row7", 2, 3);
        test_random;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_table_checker.md
# mult_table_checker

Upstream sequencer for the 8x8 times-table memory (`Multiplyer`). On a start pulse it sweeps every operand pair, a = 0..7 outer loop and b = 0..7 inner loop. For each pair it drives `a`, `b` and a one-cycle `read` strobe into the memory, waits the memory's fixed read latency, and captures `result`. It then compares the captured value against an internally computed product and reports pass/fail, the mismatch count and the first failing pair. It is used as the built-in self-check in front of the memory on the board and in simulation.

## Interface

Parameters:
- `READ_LAT`, default 1. Cycles from the edge that samples `read` high to the edge at which `result` is valid. Legal range 1..7.
- `RESULT_W`, default 6. Width of the memory result. The expected product is truncated to `RESULT_W` LSBs before comparison.

Ports:
- `clk`  in  1. Single clock; everything is on the rising edge.
- `rst_n`  in  1. Asynchronous, active-low reset.
- `start`  in  1. Single-cycle request to begin a sweep. Sampled only in IDLE or DONE.
- `a`  out  3. Operand to the memory. Registered.
- `b`  out  3. Operand to the memory. Registered.
- `read`  out  1. Read strobe to the memory. High for exactly one cycle per pair.
- `result`  in  `RESULT_W`. Read data from the memory.
- `busy`  out  1. High from ISSUE through CHECK.
- `done`  out  1. High while in DONE.
- `pass`  out  1. Valid when `done` is high. 1 if `err_count` is 0.
- `err_count`  out  7. Number of mismatching pairs, 0..64. Saturation cannot occur.
- `first_err_a`  out  3. `a` of the first mismatch. Holds 0 if there were no mismatches.
- `first_err_b`  out  3. `b` of the first mismatch. Holds 0 if there were no mismatches.

## Operation

- States:
  - IDLE: reset state.
  - ISSUE: drive the strobe.
  - WAIT: count latency.
  - CHECK: compare.
  - DONE: report.
- IDLE/DONE: on `start`=1, clear `err_count`, `first_err_*`, the operand counter {a,b}=0 and the error-seen flag, then go to ISSUE.
- ISSUE: `read`=1. Load the latency counter with READ_LAT-1. Go to WAIT.
- WAIT: stay for exactly READ_LAT cycles, then go to CHECK.
- CHECK:
  - Registered capture: compare the captured `result` with (a*b)[RESULT_W-1:0]. The product is 6 bits wide, computed combinationally from the current a,b.
  - On mismatch: increment `err_count`. If this is the first mismatch, latch `first_err_a/b`.
  - If {a,b}=63, go to DONE. Otherwise increment {a,b} as a 6-bit counter (b wraps 7→0 and carries into a) and go to ISSUE.
- DONE: `done`=1, `pass`=(err_count==0). The result registers hold until the next `start`.
- `start` is ignored while `busy`; no restart mid-sweep.
- `a`, `b` remain stable from ISSUE through CHECK of the same pair.

## Timing

- Reset values: state=IDLE, `a`=0, `b`=0, `read`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_a`=0, `first_err_b`=0.
- Each pair takes READ_LAT+2 cycles: ISSUE 1, WAIT READ_LAT, CHECK 1.
- `result` is sampled at the edge ending the last WAIT cycle, which is READ_LAT edges after the edge that saw `read`=1.
- With READ_LAT=1 and `start` sampled at edge 0:
  - Pair k has `read` high in the cycle after edge 3k.
  - `done` is first high after edge 192.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronously). The partial sweep is discarded.
- `start` high in the same cycle that DONE is entered: not sampled; DONE is held for at least one cycle.
- RESULT_W<6: the comparison uses truncated LSBs, so 7x7=49 compares as 49 mod 2^RESULT_W.

## Structure

- Shared package `mult_pkg`:
  - State encoding constants.
  - Operand width (3).
  - Pair count (64).
  - Product width (6).
- Optional sub-module `lat_counter`: a loadable down-counter with a zero flag, used for WAIT. Everything else stays in one module.

## Test plan

- Reset, then `start` with a correct behavioural memory, READ_LAT=1 → 64 `read` pulses, `done` after 192 edges, `pass`=1, `err_count`=0.
- Memory model returns 0 for a=5,b=3 → `err_count`=1, `first_err_a`=5, `first_err_b`=3, `pass`=0.
- Memory model corrupts all pairs with a=7 (7 of 8 wrong, since 7x0 stays correct) → `err_count`=7, first error at (7,1).
- READ_LAT=3 build → 5 cycles per pair, `done` after 320 edges, `result` sampled exactly 3 edges after each `read`.
- `rst_n` pulsed low during pair 20 → `busy`/`read`/`err_count` go to 0 at once. A new `start` then produces a full, clean 64-pair sweep.
- `start` held high throughout → no restart while busy. A second sweep begins on the cycle after DONE is entered, and `err_count` is cleared.
